// File: rtl/vx_cta_launcher.sv
// Per-core CTA launcher: accepts CTAs from the KMU, spawns their warps
// and reports CTA completion once every warp of a CTA has exited.
module vx_cta_launcher #(
    parameter int NUM_WARPS = 4,
    parameter int MAX_CTAS  = 2,
    localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SLOT_W = (MAX_CTAS > 1) ? $clog2(MAX_CTAS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              core_ready,
    input  logic [31:0]       task_start_pc,
    input  logic [31:0]       task_param,
    input  logic [31:0]       task_num_warps,
    input  logic [31:0]       task_cta_x,
    input  logic [31:0]       task_cta_y,
    input  logic [31:0]       task_cta_z,
    input  logic [31:0]       task_cta_id,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [WID_W-1:0]  spawn_wid,
    output logic [31:0]       spawn_pc,
    output logic [31:0]       spawn_param,
    output logic [31:0]       spawn_cta_id,
    output logic [SLOT_W-1:0] spawn_slot,
    input  logic              exit_valid,
    input  logic [WID_W-1:0]  exit_wid,
    output logic              cta_done,
    output logic [31:0]       cta_done_id,
    output logic              busy,
    output logic              err
);

    typedef enum logic {IDLE, SPAWN} state_t;

    state_t              state_q, state_d;
    logic [NUM_WARPS-1:0] warp_busy_q;
    logic [SLOT_W-1:0]   warp_slot_q [NUM_WARPS];
    logic [MAX_CTAS-1:0] slot_vld_q;
    logic [31:0]         slot_pc_q    [MAX_CTAS];
    logic [31:0]         slot_param_q [MAX_CTAS];
    logic [31:0]         slot_id_q    [MAX_CTAS];
    logic [31:0]         slot_rem_q   [MAX_CTAS];
    logic [SLOT_W-1:0]   cur_slot_q;
    logic [31:0]         issued_q;
    logic [31:0]         cur_nw_q;
    logic                hold_q;
    logic [WID_W-1:0]    held_wid_q;
    logic                done_q;
    logic [31:0]         done_id_q;
    logic                err_q;

    logic [31:0]       free_cnt;
    logic [WID_W-1:0]  low_wid;
    logic [SLOT_W-1:0] low_slot;
    logic              slot_free;
    logic [31:0]       nw;
    logic              oversize;
    logic              accept;
    logic              spawn_fire;
    logic              last_spawn;
    logic              exit_hit;
    logic [SLOT_W-1:0] exit_slot;
    logic              unused_ok;

    always_comb begin
        free_cnt  = '0;
        low_wid   = '0;
        slot_free = 1'b0;
        low_slot  = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (!warp_busy_q[i]) begin
                free_cnt = free_cnt + 32'd1;
                low_wid  = WID_W'(i);
            end
        end
        for (int j = MAX_CTAS - 1; j >= 0; j--) begin
            if (!slot_vld_q[j]) begin
                slot_free = 1'b1;
                low_slot  = SLOT_W'(j);
            end
        end
    end

    always_comb begin
        nw       = task_num_warps;
        oversize = 1'b0;
        if (task_num_warps == 32'd0) begin
            nw = 32'd1;
        end else if (task_num_warps > 32'(NUM_WARPS)) begin
            nw       = 32'(NUM_WARPS);
            oversize = 1'b1;
        end
    end

    assign core_ready = (state_q == IDLE) && reset && slot_free
                        && (free_cnt >= nw);
    assign accept     = core_ready && (task_cta_x != 32'hFFFF_FFFF);

    // A stalled request keeps its warp even if a lower one frees up.
    assign spawn_valid  = (state_q == SPAWN);
    assign spawn_wid    = hold_q ? held_wid_q : low_wid;
    assign spawn_fire   = spawn_valid && spawn_ready;
    assign last_spawn   = (issued_q + 32'd1) == cur_nw_q;
    assign spawn_pc     = spawn_valid ? slot_pc_q[cur_slot_q] : '0;
    assign spawn_param  = spawn_valid ? slot_param_q[cur_slot_q] : '0;
    assign spawn_cta_id = spawn_valid ? slot_id_q[cur_slot_q] : '0;
    assign spawn_slot   = spawn_valid ? cur_slot_q : '0;

    assign exit_hit  = exit_valid && warp_busy_q[exit_wid];
    assign exit_slot = warp_slot_q[exit_wid];

    assign cta_done    = done_q;
    assign cta_done_id = done_id_q;
    assign busy        = (state_q != IDLE) || (|slot_vld_q);
    assign err         = err_q;
    assign unused_ok   = ^{task_cta_y, task_cta_z};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SPAWN;
            SPAWN: if (spawn_fire && last_spawn) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warp_busy_q <= '0;
            slot_vld_q  <= '0;
            cur_slot_q  <= '0;
            issued_q    <= '0;
            cur_nw_q    <= '0;
            hold_q      <= 1'b0;
            held_wid_q  <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) warp_slot_q[i] <= '0;
            for (int j = 0; j < MAX_CTAS; j++) begin
                slot_pc_q[j]    <= '0;
                slot_param_q[j] <= '0;
                slot_id_q[j]    <= '0;
                slot_rem_q[j]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                slot_vld_q[low_slot]   <= 1'b1;
                slot_pc_q[low_slot]    <= task_start_pc;
                slot_param_q[low_slot] <= task_param;
                slot_id_q[low_slot]    <= task_cta_id;
                slot_rem_q[low_slot]   <= nw;
                cur_slot_q             <= low_slot;
                cur_nw_q               <= nw;
                issued_q               <= '0;
                hold_q                 <= 1'b0;
                if (oversize) err_q <= 1'b1;
            end
            if (spawn_fire) begin
                warp_busy_q[spawn_wid] <= 1'b1;
                warp_slot_q[spawn_wid] <= cur_slot_q;
                issued_q               <= issued_q + 32'd1;
                hold_q                 <= 1'b0;
            end else if (spawn_valid) begin
                hold_q     <= 1'b1;
                held_wid_q <= spawn_wid;
            end
            // Remaining counts unissued warps, so a CTA cannot finish mid-spawn.
            if (exit_hit) begin
                warp_busy_q[exit_wid] <= 1'b0;
                slot_rem_q[exit_slot] <= slot_rem_q[exit_slot] - 32'd1;
                if (slot_rem_q[exit_slot] == 32'd1) begin
                    slot_vld_q[exit_slot] <= 1'b0;
                    done_q                <= 1'b1;
                    done_id_q             <= slot_id_q[exit_slot];
                end
            end else if (exit_valid) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_cta_launcher.sv
// Bench for vx_cta_launcher: directed scenarios plus randomized traffic
// checked against a CTA/warp bookkeeping model.
module tb_vx_cta_launcher;

    localparam int NW = 4;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_ready;
    logic [31:0] task_start_pc, task_param, task_num_warps;
    logic [31:0] task_cta_x, task_cta_y, task_cta_z, task_cta_id;
    logic        spawn_valid, spawn_ready;
    logic [1:0]  spawn_wid;
    logic [31:0] spawn_pc, spawn_param, spawn_cta_id;
    logic [0:0]  spawn_slot;
    logic        exit_valid;
    logic [1:0]  exit_wid;
    logic        cta_done;
    logic [31:0] cta_done_id;
    logic        busy, err;

    always #5 clk = ~clk;

    vx_cta_launcher #(.NUM_WARPS(NW), .MAX_CTAS(MC)) dut (
        .clk(clk), .reset(reset), .core_ready(core_ready),
        .task_start_pc(task_start_pc), .task_param(task_param),
        .task_num_warps(task_num_warps), .task_cta_x(task_cta_x),
        .task_cta_y(task_cta_y), .task_cta_z(task_cta_z),
        .task_cta_id(task_cta_id), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .spawn_wid(spawn_wid),
        .spawn_pc(spawn_pc), .spawn_param(spawn_param),
        .spawn_cta_id(spawn_cta_id), .spawn_slot(spawn_slot),
        .exit_valid(exit_valid), .exit_wid(exit_wid),
        .cta_done(cta_done), .cta_done_id(cta_done_id),
        .busy(busy), .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: warp ownership by CTA sequence number.
    bit          m_busy [NW];
    int          m_own  [NW];
    int          cta_rem [int];
    logic [31:0] cta_idv [int];
    int          m_seq;
    bit          m_sp;
    int          m_left;
    logic [31:0] m_cid, m_pc, m_par;
    bit          m_hold;
    int          m_held;
    bit          m_done;
    logic [31:0] m_done_id;
    bit          m_err;
    int          dut_fire;

    logic        obs_ready, obs_sv;
    logic [1:0]  obs_wid;
    logic [31:0] obs_cid;

    function automatic int free_cnt();
        int c = 0;
        for (int i = 0; i < NW; i++) if (!m_busy[i]) c++;
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NW; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic int clamp_nw(input logic [31:0] n, output bit ovs);
        ovs = 1'b0;
        if (n == 32'd0) return 1;
        if (n > 32'(NW)) begin
            ovs = 1'b1;
            return NW;
        end
        return int'(n);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NW; i++) begin
            m_busy[i] = 1'b0;
            m_own[i]  = 0;
        end
        cta_rem.delete();
        cta_idv.delete();
        m_sp   = 1'b0;
        m_left = 0;
        m_hold = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic idle_in();
        task_cta_x     = 32'hFFFF_FFFF;
        task_num_warps = 32'd1;
        spawn_ready    = 1'b1;
        exit_valid     = 1'b0;
        exit_wid       = 2'd0;
    endtask

    task automatic offer(input logic [31:0] n, input logic [31:0] id);
        task_cta_x     = $urandom_range(0, 1000);
        task_cta_y     = $urandom;
        task_cta_z     = $urandom;
        task_num_warps = n;
        task_cta_id    = id;
        task_start_pc  = $urandom;
        task_param     = $urandom;
    endtask

    // Inputs are set by the caller at a negedge; one clock edge is applied.
    task automatic step();
        int  exp_nw, w, s;
        bit  ovs, exp_ready, ex_busy;
        #1;
        exp_nw    = clamp_nw(task_num_warps, ovs);
        exp_ready = !m_sp && (cta_rem.num() < MC) && (free_cnt() >= exp_nw);
        obs_ready = core_ready;
        obs_sv    = spawn_valid;
        obs_wid   = spawn_wid;
        obs_cid   = spawn_cta_id;
        if (spawn_valid && spawn_ready) dut_fire++;
        check("core_ready", 32'(core_ready), 32'(exp_ready));
        check("spawn_valid", 32'(spawn_valid), 32'(m_sp));
        w = m_hold ? m_held : lowest_free();
        if (m_sp) begin
            check("spawn_wid", 32'(spawn_wid), 32'(w));
            check("spawn_cta_id", spawn_cta_id, m_cid);
            check("spawn_pc", spawn_pc, m_pc);
            check("spawn_param", spawn_param, m_par);
        end
        ex_busy = m_busy[exit_wid];
        m_done  = 1'b0;
        if (m_sp) begin
            if (spawn_ready) begin
                m_busy[w] = 1'b1;
                m_own[w]  = m_seq;
                m_left--;
                m_hold = 1'b0;
                if (m_left == 0) m_sp = 1'b0;
            end else begin
                m_hold = 1'b1;
                m_held = w;
            end
        end
        if (exit_valid) begin
            if (ex_busy) begin
                s = m_own[exit_wid];
                m_busy[exit_wid] = 1'b0;
                cta_rem[s]--;
                if (cta_rem[s] == 0) begin
                    m_done    = 1'b1;
                    m_done_id = cta_idv[s];
                    cta_rem.delete(s);
                    cta_idv.delete(s);
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (exp_ready && task_cta_x != 32'hFFFF_FFFF) begin
            m_seq++;
            cta_rem[m_seq] = exp_nw;
            cta_idv[m_seq] = task_cta_id;
            m_sp   = 1'b1;
            m_left = exp_nw;
            m_cid  = task_cta_id;
            m_pc   = task_start_pc;
            m_par  = task_param;
            m_hold = 1'b0;
            if (ovs) m_err = 1'b1;
        end
        @(negedge clk);
        check("cta_done", 32'(cta_done), 32'(m_done));
        if (m_done) check("cta_done_id", cta_done_id, m_done_id);
        check("busy", 32'(busy), 32'(m_sp || cta_rem.num() > 0));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_in();
        #1;
        check("rst_ready", 32'(core_ready), 0);
        check("rst_spawn", 32'(spawn_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(cta_done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_pc", spawn_pc, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        m_seq = 0;
        dut_fire = 0;
        task_cta_y = 0; task_cta_z = 0; task_cta_id = 0;
        task_start_pc = 0; task_param = 0;
        idle_in();
        model_clear();
        @(negedge clk);

        do_reset();
        offer(2, 5); step();
        check("t1_ready", 32'(obs_ready), 1);
        idle_in(); step();
        check("t1_wid0", 32'(obs_wid), 0);
        step();
        check("t1_wid1", 32'(obs_wid), 1);
        exit_valid = 1'b1; exit_wid = 2'd0; step();
        exit_wid = 2'd1; step();
        exit_valid = 1'b0;
        check("t1_done", 32'(cta_done), 1);
        check("t1_done_id", cta_done_id, 5);

        do_reset();
        offer(3, 10); step();
        idle_in(); repeat (3) step();
        offer(2, 11); step();
        check("t2_blocked", 32'(obs_ready), 0);
        exit_valid = 1'b1; exit_wid = 2'd1; step();
        exit_valid = 1'b0; step();
        check("t2_ready", 32'(obs_ready), 1);
        idle_in(); step();
        check("t2_wid", 32'(obs_wid), 1);
        step();
        check("t2_wid2", 32'(obs_wid), 3);

        do_reset();
        offer(1, 9); step();
        idle_in(); spawn_ready = 1'b0; dut_fire = 0;
        repeat (3) begin
            step();
            check("t3_wid", 32'(obs_wid), 0);
            check("t3_cid", obs_cid, 9);
        end
        spawn_ready = 1'b1; step();
        step();
        check("t3_one", 32'(dut_fire), 1);
        check("t3_sv_off", 32'(obs_sv), 0);

        do_reset();
        task_cta_id = 3; step();
        check("t4_ready", 32'(obs_ready), 1);
        step();
        check("t4_sv", 32'(obs_sv), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_ready2", 32'(obs_ready), 1);

        do_reset();
        dut_fire = 0;
        offer(0, 20); step();
        idle_in(); step(); step();
        check("t5_one", 32'(dut_fire), 1);
        exit_valid = 1'b1; exit_wid = 2'd0; step();
        exit_valid = 1'b0;
        check("t5_done", 32'(cta_done), 1);
        dut_fire = 0;
        offer(7, 21); step();
        idle_in(); repeat (5) step();
        check("t5_four", 32'(dut_fire), 4);
        check("t5_err", 32'(err), 1);

        do_reset();
        offer(3, 30); step();
        idle_in(); step();
        check("t6_sv", 32'(spawn_valid), 1);
        do_reset();
        step();
        check("t6_ready", 32'(obs_ready), 1);
        check("t6_nodone", 32'(cta_done), 0);
        exit_valid = 1'b1; exit_wid = 2'd0; step();
        exit_valid = 1'b0;
        check("t6_err", 32'(err), 1);

        do_reset();
        repeat (3000) begin
            int bl[$];
            offer($urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 3) == 0) task_cta_x = 32'hFFFF_FFFF;
            spawn_ready = ($urandom_range(0, 2) != 0);
            exit_valid  = 1'b0;
            for (int i = 0; i < NW; i++) if (m_busy[i]) bl.push_back(i);
            if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
                exit_valid = 1'b1;
                exit_wid   = 2'(bl[$urandom_range(0, bl.size() - 1)]);
            end
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
